pipe_ctrl_unit: RTL and testbench

//   Pipelined successor to the single-cycle opcode decoder.
//   - Decodes the ID-stage opcode/funct into a control word and registers it into the ID/EX stage.
//   - Owns hazard control: load-use stall, multi-cycle MDU busy stall and EX-redirect flush.
//   - Drives the IF/ID hold/flush strobes. Sits between the IF/ID register and the EX datapath.

---
 rtl/pipe_ctrl_unit_pkg.sv | 65 ++++++
 rtl/pipe_ctrl_unit_ctrl_decode.sv | 50 +++++
 rtl/pipe_ctrl_unit.sv | 107 ++++++++++
 tb/tb_pipe_ctrl_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared opcode/funct codes, control-word layout and decode helpers for pipe_ctrl_unit.
package pipe_ctrl_unit_pkg;

  localparam int unsigned ALU_OP_LENGTH = 3;

  localparam logic [5:0] OP_R_TYPE = 6'h00;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FUNCT_MFHI = 6'h10;
  localparam logic [5:0] FUNCT_MFLO = 6'h12;
  localparam logic [5:0] FUNCT_MULT = 6'h18;
  localparam logic [5:0] FUNCT_DIV  = 6'h1A;

  // Bit positions above the ALUOp field; absolute index = ALU_OP_LENGTH + offset.
  localparam int unsigned CTRL_EXTEND_OFS   = 0;
  localparam int unsigned CTRL_REGWRITE_OFS = 1;
  localparam int unsigned CTRL_ALUSRC_OFS   = 2;
  localparam int unsigned CTRL_MEMWRITE_OFS = 3;
  localparam int unsigned CTRL_MEMREAD_OFS  = 4;
  localparam int unsigned CTRL_WRMUX_OFS    = 5;
  localparam int unsigned CTRL_JMP_OFS      = 6;
  localparam int unsigned CTRL_BRANCH_OFS   = 7;
  localparam int unsigned CTRL_REGDST_OFS   = 8;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_OR    = 3'd2,
    ALU_XOR   = 3'd3,
    ALU_LUI   = 3'd4,
    ALU_SUBNE = 3'd5,
    ALU_FUNCT = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic    reg_dst;
    logic    branch;
    logic    jmp;
    logic    write_reg_mux;
    logic    memread;
    logic    memwrite;
    logic    alu_src;
    logic    reg_write;
    logic    extend_op;
    alu_op_e alu_op;
  } ctrl_fields_t;

  function automatic logic is_known_funct(input logic [5:0] funct);
    case (funct)
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
      FUNCT_MFHI, FUNCT_MFLO, FUNCT_MULT, FUNCT_DIV: is_known_funct = 1'b1;
      default:                                       is_known_funct = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_ctrl_unit_ctrl_decode.sv
// Combinational opcode/funct to control-word table; unknown encodings yield word 0 plus illegal.
module ctrl_decode #(
  parameter int unsigned ALU_OP_LENGTH = pipe_ctrl_unit_pkg::ALU_OP_LENGTH
) (
  input  logic [5:0]               op,
  input  logic [5:0]               funct,
  output logic [ALU_OP_LENGTH+8:0] ctrl,
  output logic                     illegal
);
  import pipe_ctrl_unit_pkg::*;

  ctrl_fields_t f;

  always_comb begin
    f       = '0;
    illegal = 1'b0;
    case (op)
      OP_R_TYPE: begin
        if (is_known_funct(funct)) begin
          f.reg_dst   = 1'b1;
          f.reg_write = 1'b1;
          f.alu_op    = ALU_FUNCT;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_ORI:  begin f.alu_src = 1'b1; f.reg_write = 1'b1; f.alu_op = ALU_OR; end
      OP_XORI: begin f.alu_src = 1'b1; f.reg_write = 1'b1; f.alu_op = ALU_XOR; end
      OP_LUI:  begin f.alu_src = 1'b1; f.reg_write = 1'b1; f.alu_op = ALU_LUI; end
      OP_ADDI: begin
        f.alu_src = 1'b1; f.reg_write = 1'b1; f.extend_op = 1'b1; f.alu_op = ALU_ADD;
      end
      OP_LW: begin
        f.write_reg_mux = 1'b1; f.memread = 1'b1; f.alu_src = 1'b1;
        f.reg_write = 1'b1; f.extend_op = 1'b1; f.alu_op = ALU_ADD;
      end
      OP_SW: begin
        f.memwrite = 1'b1; f.alu_src = 1'b1; f.extend_op = 1'b1; f.alu_op = ALU_ADD;
      end
      OP_BEQ:  begin f.branch = 1'b1; f.extend_op = 1'b1; f.alu_op = ALU_SUB; end
      OP_BNE:  begin f.branch = 1'b1; f.extend_op = 1'b1; f.alu_op = ALU_SUBNE; end
      OP_J:    f.jmp = 1'b1;
      OP_JAL:  begin f.jmp = 1'b1; f.reg_write = 1'b1; end
      default: illegal = 1'b1;
    endcase
    ctrl = {f.reg_dst, f.branch, f.jmp, f.write_reg_mux, f.memread, f.memwrite,
            f.alu_src, f.reg_write, f.extend_op, ALU_OP_LENGTH'(f.alu_op)};
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// ID-stage control: decode into ID/EX, load-use / MDU stalls, EX-redirect flush.
// Optional perf counters (stall_cnt, flush_cnt) when CTRL_PERF_CNT_EN is defined.
module pipe_ctrl_unit #(
  parameter int unsigned ALU_OP_LENGTH = pipe_ctrl_unit_pkg::ALU_OP_LENGTH,
  parameter int unsigned REG_AW        = 5,
  parameter int unsigned MDU_LAT       = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [5:0]               id_op,
  input  logic [5:0]               id_funct,
  input  logic [REG_AW-1:0]        id_rs,
  input  logic [REG_AW-1:0]        id_rt,
  input  logic                     ex_redirect,
  output logic [ALU_OP_LENGTH+8:0] ex_ctrl,
  output logic                     ex_valid,
  output logic [REG_AW-1:0]        ex_rt,
  output logic                     hold_if_id,
  output logic                     flush_if_id,
  output logic                     mdu_busy,
  output logic                     illegal_op
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         flush_cnt
`endif
);
  import pipe_ctrl_unit_pkg::*;

  localparam int unsigned MEMREAD_BIT = ALU_OP_LENGTH + CTRL_MEMREAD_OFS;
  localparam int unsigned MDU_CW      = $clog2(MDU_LAT + 1);

  if (MDU_LAT < 1 || CNT_W < 1) begin : g_bad_cfg
    $error("pipe_ctrl_unit: MDU_LAT and CNT_W must be >= 1");
  end

  logic [ALU_OP_LENGTH+8:0] dec_ctrl;
  logic                     dec_illegal;
  logic [MDU_CW-1:0]        mdu_cnt;
  logic is_rtype, is_mdu_issue, is_mdu_read;
  logic load_use, mdu_stall, accept, mdu_start;

  ctrl_decode #(.ALU_OP_LENGTH(ALU_OP_LENGTH)) u_decode (
    .op      (id_op),
    .funct   (id_funct),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  assign mdu_busy = (mdu_cnt != '0);

  // Redirect outranks both stalls, so hold and flush are mutually exclusive by construction.
  always_comb begin
    is_rtype     = (id_op == OP_R_TYPE);
    is_mdu_issue = is_rtype & ((id_funct == FUNCT_MULT) | (id_funct == FUNCT_DIV));
    is_mdu_read  = is_rtype & ((id_funct == FUNCT_MFHI) | (id_funct == FUNCT_MFLO));
    load_use     = ex_valid & ex_ctrl[MEMREAD_BIT] & id_valid & (ex_rt != '0) &
                   ((ex_rt == id_rs) | (ex_rt == id_rt));
    mdu_stall    = id_valid & is_mdu_read & mdu_busy;
    flush_if_id  = ex_redirect;
    hold_if_id   = ~ex_redirect & (load_use | mdu_stall);
    accept       = ~ex_redirect & ~hold_if_id;
    mdu_start    = accept & id_valid & is_mdu_issue;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl    <= '0;
      ex_valid   <= 1'b0;
      ex_rt      <= '0;
      illegal_op <= 1'b0;
      mdu_cnt    <= '0;
    end else begin
      if (accept && id_valid) begin
        ex_ctrl    <= dec_ctrl;
        ex_valid   <= 1'b1;
        ex_rt      <= id_rt;
        illegal_op <= dec_illegal;
      end else begin
        ex_ctrl    <= '0;
        ex_valid   <= 1'b0;
        ex_rt      <= '0;
        illegal_op <= 1'b0;
      end
      if (mdu_start) begin
        mdu_cnt <= MDU_CW'(MDU_LAT);
      end else if (mdu_cnt != '0) begin
        mdu_cnt <= mdu_cnt - 1'b1;
      end
    end
  end

`ifdef CTRL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hold_if_id)  stall_cnt <= stall_cnt + 1'b1;
      if (flush_if_id) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed self-checking bench for pipe_ctrl_unit; perf-counter checks active with CTRL_PERF_CNT_EN.
module tb_pipe_ctrl_unit;

  localparam int unsigned TB_CNT_W = 4;

  localparam logic [5:0] T_R    = 6'h00;
  localparam logic [5:0] T_J    = 6'h02;
  localparam logic [5:0] T_JAL  = 6'h03;
  localparam logic [5:0] T_BEQ  = 6'h04;
  localparam logic [5:0] T_BNE  = 6'h05;
  localparam logic [5:0] T_ADDI = 6'h08;
  localparam logic [5:0] T_ORI  = 6'h0D;
  localparam logic [5:0] T_XORI = 6'h0E;
  localparam logic [5:0] T_LUI  = 6'h0F;
  localparam logic [5:0] T_LW   = 6'h23;
  localparam logic [5:0] T_SW   = 6'h2B;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_MFHI = 6'h10;
  localparam logic [5:0] F_MFLO = 6'h12;
  localparam logic [5:0] F_MULT = 6'h18;
  localparam logic [5:0] F_DIV  = 6'h1A;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [5:0]  id_op;
  logic [5:0]  id_funct;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        ex_redirect;
  logic [11:0] ex_ctrl;
  logic        ex_valid;
  logic [4:0]  ex_rt;
  logic        hold_if_id;
  logic        flush_if_id;
  logic        mdu_busy;
  logic        illegal_op;
`ifdef CTRL_PERF_CNT_EN
  logic [TB_CNT_W-1:0] stall_cnt;
  logic [TB_CNT_W-1:0] flush_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  pipe_ctrl_unit #(
    .ALU_OP_LENGTH (3),
    .REG_AW        (5),
    .MDU_LAT       (4),
    .CNT_W         (TB_CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_op       (id_op),
    .id_funct    (id_funct),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_redirect (ex_redirect),
    .ex_ctrl     (ex_ctrl),
    .ex_valid    (ex_valid),
    .ex_rt       (ex_rt),
    .hold_if_id  (hold_if_id),
    .flush_if_id (flush_if_id),
    .mdu_busy    (mdu_busy),
    .illegal_op  (illegal_op)
`ifdef CTRL_PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [11:0] ctrl;
    logic        ill;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt);
    id_valid = v;
    id_op    = op;
    id_funct = fn;
    id_rs    = rs;
    id_rt    = rt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, T_ORI,  6'h00,  12'h032, 1'b0};
    vecs[1]  = '{1'b1, T_R,    F_ADD,  12'h817, 1'b0};
    vecs[2]  = '{1'b1, T_R,    6'h25,  12'h817, 1'b0};
    vecs[3]  = '{1'b1, T_R,    6'h2A,  12'h817, 1'b0};
    vecs[4]  = '{1'b1, T_LW,   6'h00,  12'h1B8, 1'b0};
    vecs[5]  = '{1'b1, T_SW,   6'h00,  12'h068, 1'b0};
    vecs[6]  = '{1'b1, T_BEQ,  6'h00,  12'h409, 1'b0};
    vecs[7]  = '{1'b1, T_BNE,  6'h00,  12'h40D, 1'b0};
    vecs[8]  = '{1'b1, T_J,    6'h00,  12'h200, 1'b0};
    vecs[9]  = '{1'b1, T_JAL,  6'h00,  12'h210, 1'b0};
    vecs[10] = '{1'b1, T_XORI, 6'h00,  12'h033, 1'b0};
    vecs[11] = '{1'b1, T_ADDI, 6'h00,  12'h038, 1'b0};
    vecs[12] = '{1'b1, T_LUI,  6'h00,  12'h034, 1'b0};
    vecs[13] = '{1'b0, T_ORI,  6'h00,  12'h000, 1'b0};
    vecs[14] = '{1'b1, 6'h3F,  6'h00,  12'h000, 1'b1};
    vecs[15] = '{1'b1, T_R,    6'h3F,  12'h000, 1'b1};
    vecs[16] = '{1'b1, T_R,    F_MFHI, 12'h817, 1'b0};
    vecs[17] = '{1'b1, T_R,    F_MFLO, 12'h817, 1'b0};
    vecs[18] = '{1'b1, T_R,    F_MULT, 12'h817, 1'b0};
    vecs[19] = '{1'b1, T_R,    F_DIV,  12'h817, 1'b0};

    // Reset state with a live instruction presented
    rst_n       = 1'b0;
    ex_redirect = 1'b0;
    drive(1'b1, T_ORI, 6'h00, 5'd0, 5'd0);
    tick();
    tick();
    chk("rst_ex_ctrl", 32'(ex_ctrl), 32'h0);
    chk("rst_ex_valid", 32'(ex_valid), 32'h0);
    chk("rst_hold_flush", 32'({hold_if_id, flush_if_id}), 32'h0);
    chk("rst_mdu_illegal", 32'({mdu_busy, illegal_op}), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rst_first_ori", 32'(ex_ctrl), 32'h032);
    chk("rst_first_valid", 32'(ex_valid), 32'h1);

    // Decode table, one instruction per cycle, no hazards expected
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].v, vecs[i].op, vecs[i].fn, 5'd0, 5'd0);
      #1;
      chk($sformatf("vec%0d_hold_flush", i), 32'({hold_if_id, flush_if_id}), 32'h0);
      tick();
      chk($sformatf("vec%0d_ctrl", i), 32'(ex_ctrl), 32'(vecs[i].ctrl));
      chk($sformatf("vec%0d_valid", i), 32'(ex_valid), 32'(vecs[i].v));
      chk($sformatf("vec%0d_illegal", i), 32'(illegal_op), 32'(vecs[i].ill));
    end

    // DIV right after MULT reloaded the counter: busy for 4 more cycles
    drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0);
    tick(); tick(); tick();
    chk("mdu_reload_busy", 32'(mdu_busy), 32'h1);
    tick();
    chk("mdu_reload_idle", 32'(mdu_busy), 32'h0);

    // Illegal opcode pulses for exactly one cycle
    drive(1'b1, 6'h3F, 6'h00, 5'd0, 5'd0);
    tick();
    chk("ill_pulse", 32'(illegal_op), 32'h1);
    chk("ill_ctrl", 32'(ex_ctrl), 32'h0);
    drive(1'b1, T_ORI, 6'h00, 5'd0, 5'd0);
    tick();
    chk("ill_clear", 32'(illegal_op), 32'h0);
    chk("ill_next_ctrl", 32'(ex_ctrl), 32'h032);

    // Load-use on rt=5: one hold cycle, one bubble, then ADD issues
    drive(1'b1, T_LW, 6'h00, 5'd0, 5'd5);
    tick();
    chk("lu_ex_rt", 32'(ex_rt), 32'd5);
    drive(1'b1, T_R, F_ADD, 5'd5, 5'd0);
    #1;
    chk("lu_hold", 32'({hold_if_id, flush_if_id}), 32'b10);
    tick();
    chk("lu_bubble", 32'({ex_valid, ex_ctrl}), 32'h0);
    #1;
    chk("lu_hold_released", 32'(hold_if_id), 32'h0);
    tick();
    chk("lu_add_issue", 32'({ex_valid, ex_ctrl}), 32'h1817);

    // Load to r0 never stalls
    drive(1'b1, T_LW, 6'h00, 5'd0, 5'd0);
    tick();
    drive(1'b1, T_R, F_ADD, 5'd0, 5'd0);
    #1;
    chk("lu_r0_nohold", 32'(hold_if_id), 32'h0);
    tick();
    chk("lu_r0_issue", 32'({ex_valid, ex_ctrl}), 32'h1817);

    // MULT then MFLO: four hold cycles
    drive(1'b1, T_R, F_MULT, 5'd0, 5'd0);
    tick();
    chk("mdu_busy_set", 32'(mdu_busy), 32'h1);
    drive(1'b1, T_R, F_MFLO, 5'd0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("mdu_hold%0d", i), 32'(hold_if_id), 32'h1);
      tick();
      chk($sformatf("mdu_bubble%0d", i), 32'(ex_valid), 32'h0);
    end
    #1;
    chk("mdu_done", 32'({mdu_busy, hold_if_id}), 32'h0);
    tick();
    chk("mdu_mflo_issue", 32'({ex_valid, ex_ctrl}), 32'h1817);

    // Redirect during a load-use stall on a MULT: flush wins, MDU never starts
    drive(1'b1, T_LW, 6'h00, 5'd0, 5'd7);
    tick();
    drive(1'b1, T_R, F_MULT, 5'd7, 5'd0);
    #1;
    chk("rd_pre_hold", 32'(hold_if_id), 32'h1);
    ex_redirect = 1'b1;
    #1;
    chk("rd_flush_only", 32'({hold_if_id, flush_if_id}), 32'b01);
    tick();
    ex_redirect = 1'b0;
    chk("rd_bubble", 32'({ex_valid, ex_ctrl}), 32'h0);
    chk("rd_no_mdu", 32'(mdu_busy), 32'h0);
    drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0);
    tick();

`ifdef CTRL_PERF_CNT_EN
    chk("perf_stall5", 32'(stall_cnt), 32'd5);
    chk("perf_flush1", 32'(flush_cnt), 32'd1);
    // Eleven more stalls bring the 4-bit counter to 16, i.e. wrap to 0
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, T_LW, 6'h00, 5'd0, 5'd5);
      tick();
      drive(1'b1, T_R, F_ADD, 5'd5, 5'd0);
      tick();
      tick();
    end
    drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0);
    tick();
    chk("perf_stall_wrap", 32'(stall_cnt), 32'd0);
    chk("perf_flush_keep", 32'(flush_cnt), 32'd1);
`endif

    // Asynchronous reset in the middle of an MDU stall
    drive(1'b1, T_R, F_MULT, 5'd0, 5'd0);
    tick();
    drive(1'b1, T_R, F_MFHI, 5'd0, 5'd0);
    #1;
    chk("arst_pre_hold", 32'(hold_if_id), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_mdu_clear", 32'({mdu_busy, hold_if_id}), 32'h0);
    chk("arst_ex_clear", 32'({ex_valid, ex_ctrl}), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_mfhi_issue", 32'({ex_valid, ex_ctrl}), 32'h1817);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
